// File: rtl/rom_prefetcher_pkg.sv
// rom_prefetcher_pkg: shared FSM encoding and fetch stride for the ROM prefetcher
package rom_prefetcher_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] WORD_INC = 32'd4;

endpackage

// File: rtl/rom_prefetcher_fetch_fifo.sv
// fetch_fifo: {addr,data} instruction buffer with flush and empty-bypass so a word is visible the cycle it arrives
module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [63:0]              wdata_i,
    output logic                     valid_o,
    output logic [63:0]              rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic empty;
    logic wr_en;
    logic rd_en;

    // a word popped the same cycle it arrives into an empty buffer never gets stored
    always_comb begin
        empty   = (count == '0);
        wr_en   = push_i && !flush_i && !(pop_i && empty);
        rd_en   = pop_i && !empty;
        valid_o = !empty || push_i;
        rdata_o = empty ? wdata_i : mem[rd_ptr];
        count_o = count;
    end

    // pointers and occupancy; flush empties the buffer
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/rom_prefetcher.sv
// rom_prefetcher: sequential ROM fetch engine feeding a small instruction buffer
module rom_prefetcher
    import rom_prefetcher_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] boot_addr_i,
    input  logic        stop_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);

    state_t state_q;
    state_t state_d;
    logic inflight_q;
    logic [31:0] fetch_addr_q;
    logic [31:0] req_addr_q;
    logic [$clog2(DEPTH):0] count;
    logic fifo_valid;
    logic [63:0] head;
    logic redirect_ok;
    logic push;
    logic pop;

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    // next state: redirect wins over stop and keeps the engine running
    always_comb begin
        state_d = (state_q == IDLE) ? (start_i ? RUN : IDLE)
                                    : ((stop_i && !redirect_i) ? IDLE : RUN);
    end

    // outputs: request only with room for the reply, never while redirecting or stopping
    always_comb begin
        redirect_ok   = redirect_i && (state_q == RUN);
        rom_req_o     = !rst_i && (state_q == RUN) && !redirect_i && !stop_i &&
                        (int'(count) + int'(inflight_q) < DEPTH);
        rom_addr_o    = rst_i ? 32'd0 : fetch_addr_q;
        busy_o        = !rst_i && ((state_q == RUN) || inflight_q);
        push          = !rst_i && inflight_q && !redirect_ok;
        instr_valid_o = !rst_i && fifo_valid;
        pop           = instr_valid_o && instr_ready_i;
        instr_addr_o  = head[63:32];
        instr_o       = head[31:0];
    end

    // fetch address, in-flight flag and address of the outstanding request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q   <= 1'b0;
            fetch_addr_q <= 32'd0;
            req_addr_q   <= 32'd0;
        end else begin
            inflight_q <= rom_req_o;
            if (rom_req_o) req_addr_q <= fetch_addr_q;
            if (state_q == IDLE && start_i) fetch_addr_q <= {boot_addr_i[31:2], 2'b00};
            else if (redirect_ok) fetch_addr_q <= {redirect_addr_i[31:2], 2'b00};
            else if (rom_req_o) fetch_addr_q <= fetch_addr_q + WORD_INC;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_ok),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({req_addr_q, rom_rdata_i}),
        .valid_o (fifo_valid),
        .rdata_o (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_rom_prefetcher.sv
// tb_rom_prefetcher: directed vector table plus latency/redirect sequences; ROM word at address a is ~a
module tb_rom_prefetcher;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] boot_addr_i;
    logic        stop_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_ready_i;
    logic        busy_o;

    rom_prefetcher #(.DEPTH(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .boot_addr_i     (boot_addr_i),
        .stop_i          (stop_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .rom_req_o       (rom_req_o),
        .rom_addr_o      (rom_addr_o),
        .rom_rdata_i     (rom_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_addr_o    (instr_addr_o),
        .instr_ready_i   (instr_ready_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        start;
        logic [31:0] boot;
        logic        stop;
        logic        redir;
        logic [31:0] raddr;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] iaddr;
        logic        busy;
    } vec_t;

    vec_t tab[$];
    int total = 0;
    int bad = 0;
    logic pend_req;
    logic [31:0] pend_addr;

    function automatic vec_t mk(logic rst, logic start, logic [31:0] boot, logic stop, logic redir,
                                logic [31:0] raddr, logic ready, logic req, logic [31:0] addr,
                                logic valid, logic [31:0] iaddr, logic busy);
        vec_t v;
        v.rst = rst; v.start = start; v.boot = boot; v.stop = stop; v.redir = redir;
        v.raddr = raddr; v.ready = ready; v.req = req; v.addr = addr; v.valid = valid;
        v.iaddr = iaddr; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ROM model: answers the request seen this cycle with ~addr during the next cycle
    task automatic tick();
        pend_req = rom_req_o;
        pend_addr = rom_addr_o;
        @(negedge clk_i);
        rom_rdata_i = pend_req ? ~pend_addr : 32'h0BAD0BAD;
    endtask

    localparam logic [31:0] B = 32'h1A000080;

    initial begin
        int lat;
        logic [31:0] first;
        rst_i = 1; start_i = 0; boot_addr_i = 0; stop_i = 0; redirect_i = 0;
        redirect_addr_i = 0; instr_ready_i = 0; rom_rdata_i = 0;
        // reset, then boot with consumer stalled: exactly two requests, head held
        tab.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0));
        tab.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,1,B,0,0,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,B,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,B+4,1,B,1));
        for (int i = 0; i < 9; i++) tab.push_back(mk(0,0,0,0,0,0,0, 0,B+8,1,B,1));
        // release consumer, stream one word per cycle
        tab.push_back(mk(0,0,0,0,0,0,1, 0,B+8,1,B,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,B+8,1,B+4,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,B+12,1,B+8,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,B+16,1,B+12,1));
        // redirect kills B+16 in flight
        tab.push_back(mk(0,0,0,0,1,32'h1A000200,1, 0,B+20,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,32'h1A000200,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,32'h1A000204,1,32'h1A000200,1));
        // stop with one response in flight: word still delivered, then idle
        tab.push_back(mk(0,0,0,1,0,0,1, 0,32'h1A000208,1,32'h1A000204,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 0,32'h1A000208,0,0,0));
        // boot at top of address space, low bits ignored, wrap to 0
        tab.push_back(mk(0,1,32'hFFFFFFFE,0,0,0,1, 0,32'h1A000208,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,32'hFFFFFFFC,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,32'h0,1,32'hFFFFFFFC,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,32'h4,1,32'h0,1));
        // fill buffer then reset mid-run
        tab.push_back(mk(0,0,0,0,0,0,0, 1,32'h8,1,32'h4,1));
        tab.push_back(mk(0,0,0,0,0,0,0, 0,32'hC,1,32'h4,1));
        tab.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0));
        // redirect+stop together with a handshake: handshake seen, redirect wins
        tab.push_back(mk(0,1,32'h100,0,0,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,32'h100,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,32'h104,1,32'h100,1));
        tab.push_back(mk(0,0,0,1,1,32'h300,1, 0,32'h108,1,32'h100,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,32'h300,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0,1, 1,32'h304,1,32'h300,1));
        // start ignored in RUN, redirect ignored in IDLE
        tab.push_back(mk(0,1,32'h500,0,0,0,1, 1,32'h308,1,32'h304,1));
        tab.push_back(mk(0,0,0,1,0,0,1, 0,32'h30C,1,32'h308,1));
        tab.push_back(mk(0,0,0,0,1,32'h700,1, 0,32'h30C,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,1, 0,32'h30C,0,0,0));

        @(negedge clk_i);
        foreach (tab[i]) begin
            rst_i = tab[i].rst; start_i = tab[i].start; boot_addr_i = tab[i].boot;
            stop_i = tab[i].stop; redirect_i = tab[i].redir; redirect_addr_i = tab[i].raddr;
            instr_ready_i = tab[i].ready;
            #1;
            chk($sformatf("row%0d req", i), 32'(rom_req_o), 32'(tab[i].req));
            chk($sformatf("row%0d addr", i), rom_addr_o, tab[i].addr);
            chk($sformatf("row%0d valid", i), 32'(instr_valid_o), 32'(tab[i].valid));
            chk($sformatf("row%0d busy", i), 32'(busy_o), 32'(tab[i].busy));
            if (tab[i].valid) begin
                chk($sformatf("row%0d iaddr", i), instr_addr_o, tab[i].iaddr);
                chk($sformatf("row%0d instr", i), instr_o, ~tab[i].iaddr);
            end
            tick();
        end

        // first-instruction latency with a streaming consumer
        rst_i = 1; start_i = 0; stop_i = 0; redirect_i = 0; instr_ready_i = 1;
        #1; tick();
        rst_i = 0; start_i = 1; boot_addr_i = 32'h1A000000;
        #1; tick();
        start_i = 0;
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            #1;
            if (instr_valid_o) lat = c;
            else tick();
        end
        chk("latency", 32'(lat), 32'd2);
        chk("lat_iaddr", instr_addr_o, 32'h1A000000);
        tick();
        // redirect while 0x1A000004 is in flight
        redirect_i = 1; redirect_addr_i = 32'h1A000200;
        #1;
        chk("redir_noreq", 32'(rom_req_o), 32'd0);
        tick();
        redirect_i = 0;
        first = 32'hFFFFFFFF;
        for (int c = 0; c < 8 && first == 32'hFFFFFFFF; c++) begin
            #1;
            if (instr_valid_o) first = instr_addr_o;
            else tick();
        end
        chk("redir_first", first, 32'h1A000200);
        chk("redir_data", instr_o, ~32'h1A000200);
        for (int k = 1; k <= 5; k++) begin
            tick();
            #1;
            chk($sformatf("stream%0d valid", k), 32'(instr_valid_o), 32'd1);
            chk($sformatf("stream%0d iaddr", k), instr_addr_o, 32'h1A000200 + 32'(4 * k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_prefetcher.md
ROM_PREFETCHER -- requirements
Module: rom_prefetcher

Interface
REQ-001 SHALL have parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-002 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port start_i, input, 1, pulse that begins fetching at boot_addr_i.
REQ-005 SHALL have port boot_addr_i, input, 32, first fetch address.
REQ-006 SHALL have port stop_i, input, 1, pulse that halts further requests.
REQ-007 SHALL have port redirect_i, input, 1, pulse that flushes and restarts at redirect_addr_i.
REQ-008 SHALL have port redirect_addr_i, input, 32, restart address.
REQ-009 SHALL have port rom_req_o, output, 1, ROM read request.
REQ-010 SHALL have port rom_addr_o, output, 32, ROM byte address, bits[1:0] always 0.
REQ-011 SHALL have port rom_rdata_i, input, 32, ROM data, valid exactly one cycle after a request.
REQ-012 SHALL have port instr_valid_o, output, 1, buffer head valid.
REQ-013 SHALL have port instr_o, output, 32, head instruction word.
REQ-014 SHALL have port instr_addr_o, output, 32, address of head word.
REQ-015 SHALL have port instr_ready_i, input, 1, consumer accepts head when high with instr_valid_o.
REQ-016 SHALL have port busy_o, output, 1, high when state is RUN or a response is in flight.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start_i; RUN->IDLE on stop_i; redirect_i keeps RUN.
REQ-018 SHALL assert rom_req_o only in RUN when occupancy + in-flight count < DEPTH, and not in the cycle redirect_i or stop_i is high.
REQ-019 SHALL fetch addresses boot_addr_i (or redirect_addr_i), then +4 per issued request, wrapping modulo 2^32; input bits[1:0] are ignored (forced 0).
REQ-020 SHALL write rom_rdata_i with its address into the buffer the cycle after each request unless that response was killed.
REQ-021 SHALL give first-instruction latency of 2 cycles: start_i at edge N -> rom_req_o in cycle N+1 -> instr_valid_o in cycle N+2.
REQ-022 SHALL sustain one instruction per cycle while instr_ready_i stays high.
REQ-023 SHALL, on redirect_i, empty the buffer and kill the response in flight; the first request to redirect_addr_i is issued the following cycle.
REQ-024 SHALL, when redirect_i coincides with a valid/ready handshake, count the handshake as completed, then flush.
REQ-025 SHALL, on stop_i, stop issuing requests; a response already in flight is still written, and buffered words remain deliverable.
REQ-026 SHALL give redirect_i priority over stop_i in the same cycle; start_i in RUN and redirect_i in IDLE are ignored.
REQ-027 SHALL, when the buffer is full and a handshake and a ROM write occur together, accept both (occupancy unchanged).
REQ-028 SHALL hold instr_o and instr_addr_o stable while instr_valid_o is high and instr_ready_i is low.

Reset
REQ-029 SHALL, while rst_i is high, force state IDLE, buffer empty, in-flight cleared, fetch address 0, rom_req_o 0, rom_addr_o 0, instr_valid_o 0, busy_o 0.
REQ-030 SHALL, on reset during RUN, discard the in-flight response; the bench drives no ROM data after reset.

Structure
REQ-031 SHALL place the FSM state enum and the word-increment constant (4) in shared package rom_prefetcher_pkg.
REQ-032 SHALL implement the buffer as sub-module fetch_fifo (DEPTH x 64-bit, with flush input).

Verification
REQ-033 SHALL cover reset then start_i with boot_addr_i=0x1A000080, ready=1 -> rom_addr_o 0x1A000080, 0x1A000084, ...; first instr_valid_o 2 cycles after start_i.
REQ-034 SHALL cover ready=0 for 10 cycles with DEPTH=2 -> exactly 2 requests issued, then rom_req_o=0 with head 0x1A000080 held.
REQ-035 SHALL cover redirect_i to 0x1A000200 while a response is in flight -> old word never appears; next valid instr_addr_o=0x1A000200.
REQ-036 SHALL cover start_i at boot_addr_i=0xFFFFFFFC -> addresses 0xFFFFFFFC then 0x00000000.
REQ-037 SHALL cover stop_i with one response in flight and ready=1 -> that word delivered, then IDLE and busy_o=0.
REQ-038 SHALL cover rst_i mid-RUN with a full buffer -> next cycle instr_valid_o=0, rom_req_o=0, busy_o=0.
